// File: rtl/max7219_pkg.sv
// Shared definitions for the MAX7219 display stage: register map, FSM states,
// init words and blank code.
package max7219_pkg;

  localparam logic [3:0] REG_DIGIT0    = 4'h1;
  localparam logic [3:0] REG_DIGIT1    = 4'h2;
  localparam logic [3:0] REG_DIGIT2    = 4'h3;
  localparam logic [3:0] REG_DIGIT3    = 4'h4;
  localparam logic [3:0] REG_DIGIT4    = 4'h5;
  localparam logic [3:0] REG_DIGIT5    = 4'h6;
  localparam logic [3:0] REG_DIGIT6    = 4'h7;
  localparam logic [3:0] REG_DIGIT7    = 4'h8;
  localparam logic [3:0] REG_DECODE    = 4'h9;
  localparam logic [3:0] REG_INTENSITY = 4'hA;
  localparam logic [3:0] REG_SCANLIM   = 4'hB;
  localparam logic [3:0] REG_SHUTDN    = 4'hC;
  localparam logic [3:0] REG_DISPTEST  = 4'hF;

  localparam logic [3:0] BLANK_CODE = 4'hF;

  typedef enum logic [2:0] {
    ST_PWRUP   = 3'd0,
    ST_INIT    = 3'd1,
    ST_IDLE    = 3'd2,
    ST_CONVERT = 3'd3,
    ST_SEND    = 3'd4
  } state_t;

  // Intensity entry carries 0 in its data field; init_word() patches it in.
  localparam logic [15:0] INIT_WORDS [6] = '{
    {4'h0, REG_DISPTEST,  8'h00},
    {4'h0, REG_SHUTDN,    8'h00},
    {4'h0, REG_SCANLIM,   8'h07},
    {4'h0, REG_DECODE,    8'hFF},
    {4'h0, REG_INTENSITY, 8'h00},
    {4'h0, REG_SHUTDN,    8'h01}
  };

  function automatic logic [15:0] init_word(input logic [2:0] idx, input logic [3:0] intensity);
    logic [15:0] w;
    case (idx)
      3'd0:    w = INIT_WORDS[0];
      3'd1:    w = INIT_WORDS[1];
      3'd2:    w = INIT_WORDS[2];
      3'd3:    w = INIT_WORDS[3];
      3'd4:    w = {INIT_WORDS[4][15:4], intensity};
      3'd5:    w = INIT_WORDS[5];
      default: w = 16'h0000;
    endcase
    return w;
  endfunction

  function automatic logic [3:0] digit_addr(input logic [2:0] idx);
    logic [3:0] a;
    case (idx)
      3'd0:    a = REG_DIGIT0;
      3'd1:    a = REG_DIGIT1;
      3'd2:    a = REG_DIGIT2;
      3'd3:    a = REG_DIGIT3;
      3'd4:    a = REG_DIGIT4;
      3'd5:    a = REG_DIGIT5;
      3'd6:    a = REG_DIGIT6;
      3'd7:    a = REG_DIGIT7;
      default: a = REG_DIGIT0;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/max7219_display_bin2bcd.sv
// Sequential double-dabble: 32-bit binary to 10 BCD digits, one bit per cycle.
// done rises on the cycle after the last iteration and holds until the next start.
module bin2bcd_seq (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] bin,
  output logic        done,
  output logic [39:0] bcd
);

  logic [31:0] bin_r;
  logic [39:0] acc_r;
  logic [5:0]  cnt_r;
  logic        done_r;
  logic [39:0] adj_s;

  // add-3 correction of every nibble that would overflow on the next shift
  always_comb begin
    adj_s = acc_r;
    for (int i = 0; i < 10; i++) begin
      if (acc_r[4*i +: 4] >= 4'd5) begin
        adj_s[4*i +: 4] = acc_r[4*i +: 4] + 4'd3;
      end else begin
        adj_s[4*i +: 4] = acc_r[4*i +: 4];
      end
    end
  end

  // load on start, then shift one binary bit into the accumulator per cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      bin_r  <= 32'h0000_0000;
      acc_r  <= 40'h00_0000_0000;
      cnt_r  <= 6'd0;
      done_r <= 1'b0;
    end else if (start) begin
      bin_r  <= bin;
      acc_r  <= 40'h00_0000_0000;
      cnt_r  <= 6'd32;
      done_r <= 1'b0;
    end else if (cnt_r != 6'd0) begin
      acc_r  <= {adj_s[38:0], bin_r[31]};
      bin_r  <= {bin_r[30:0], 1'b0};
      cnt_r  <= cnt_r - 6'd1;
      done_r <= (cnt_r == 6'd1);
    end else begin
      done_r <= done_r;
    end
  end

  assign done = done_r;
  assign bcd  = acc_r;

endmodule

// File: rtl/max7219_display.sv
// MAX7219 driver: power-up wait, init sequence, BCD refresh of eight digits on change.
// Optional leading-zero blanking with `define MAX7219_BLANK_EN.
module max7219_display
  import max7219_pkg::*;
#(
  parameter int         CLK_DIV      = 4,
  parameter logic [3:0] INTENSITY    = 4'h8,
  parameter int         PWRUP_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data_in,
  output logic        max_din,
  output logic        max_clk,
  output logic        max_load,
  output logic        busy
);

  localparam int              DIV_W     = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [15:0]      PWR_LAST = 16'(PWRUP_CYCLES - 1);
  localparam logic [5:0]       SLOT_GAP = 6'd33;

  state_t           state_r, state_s;
  logic [15:0]      pwr_r, pwr_s;
  logic [5:0]       slot_r, slot_s;
  logic [DIV_W-1:0] div_r, div_s;
  logic [2:0]       frm_r, frm_s;
  logic [2:0]       frm_last_s;
  logic [31:0]      shown_r;
  logic             conv_start_s;
  logic             bcd_done_s;
  logic [39:0]      bcd_s;
  logic             bcd_hi_unused_s;
  logic [7:0]       blank_s;
  logic [3:0]       digit_s;
  logic [7:0]       byte_s;
  logic [15:0]      word_s;
  logic             active_s;
  logic             din_r, clk_r, load_r, busy_r;

  bin2bcd_seq u_bcd (
    .clock (clock),
    .reset (reset),
    .start (conv_start_s),
    .bin   (data_in),
    .done  (bcd_done_s),
    .bcd   (bcd_s)
  );

  // digits 9 and 10 exist only because 2^32 needs them; they are never shown
  assign bcd_hi_unused_s = ^bcd_s[39:32];

`ifdef MAX7219_BLANK_EN
  // blank every zero above the highest non-zero digit; digit 1 always shows
  always_comb begin
    logic lead_s;
    lead_s  = 1'b1;
    blank_s = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      lead_s     = lead_s && (bcd_s[4*i +: 4] == 4'h0);
      blank_s[i] = lead_s && (i != 0);
    end
  end
`else
  assign blank_s = 8'h00;
`endif

  // FSM next state plus serializer slot/divider/frame counters
  always_comb begin
    state_s      = state_r;
    pwr_s        = pwr_r;
    slot_s       = slot_r;
    div_s        = div_r;
    frm_s        = frm_r;
    conv_start_s = 1'b0;
    frm_last_s   = (state_r == ST_INIT) ? 3'd5 : 3'd7;
    case (state_r)
      ST_PWRUP: begin
        if (pwr_r == PWR_LAST) begin
          state_s = ST_INIT;
          slot_s  = 6'd0;
          div_s   = '0;
          frm_s   = 3'd0;
        end else begin
          pwr_s = pwr_r + 16'd1;
        end
      end
      ST_INIT, ST_SEND: begin
        if (div_r != DIV_LAST) begin
          div_s = div_r + 1'b1;
        end else if (slot_r != SLOT_GAP) begin
          div_s  = '0;
          slot_s = slot_r + 6'd1;
        end else if (frm_r != frm_last_s) begin
          div_s  = '0;
          slot_s = 6'd0;
          frm_s  = frm_r + 3'd1;
        end else begin
          div_s  = '0;
          slot_s = 6'd0;
          frm_s  = 3'd0;
          // after INIT, one forced refresh so the digits never keep power-on junk
          if (state_r == ST_INIT) begin
            state_s      = ST_CONVERT;
            conv_start_s = 1'b1;
          end else begin
            state_s = ST_IDLE;
          end
        end
      end
      ST_IDLE: begin
        if (data_in != shown_r) begin
          state_s      = ST_CONVERT;
          conv_start_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CONVERT: begin
        if (bcd_done_s) begin
          state_s = ST_SEND;
          slot_s  = 6'd0;
          div_s   = '0;
          frm_s   = 3'd0;
        end else begin
          state_s = ST_CONVERT;
        end
      end
      default: begin
        state_s = ST_PWRUP;
        pwr_s   = 16'd0;
      end
    endcase
  end

  // word for the frame that will be on the wire next cycle
  always_comb begin
    digit_s  = bcd_s[{1'b0, frm_s, 2'b00} +: 4];
    active_s = (state_s == ST_INIT) || (state_s == ST_SEND);
    if (blank_s[frm_s]) begin
      byte_s = {4'h0, BLANK_CODE};
    end else begin
      byte_s = {4'h0, digit_s};
    end
    case (state_s)
      ST_INIT: word_s = init_word(frm_s, INTENSITY);
      ST_SEND: word_s = {4'h0, digit_addr(frm_s), byte_s};
      default: word_s = 16'h0000;
    endcase
  end

  // state, counters and pin registers; pins are decoded from the next slot
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_PWRUP;
      pwr_r   <= 16'd0;
      slot_r  <= 6'd0;
      div_r   <= '0;
      frm_r   <= 3'd0;
      shown_r <= 32'h0000_0000;
      din_r   <= 1'b0;
      clk_r   <= 1'b0;
      load_r  <= 1'b1;
      busy_r  <= 1'b1;
    end else begin
      state_r <= state_s;
      pwr_r   <= pwr_s;
      slot_r  <= slot_s;
      div_r   <= div_s;
      frm_r   <= frm_s;
      if (conv_start_s) begin
        shown_r <= data_in;
      end else begin
        shown_r <= shown_r;
      end
      // slots 0..31 carry bits MSB first (even: clk low, odd: clk high)
      if (active_s && !slot_s[5]) begin
        din_r <= word_s[~slot_s[4:1]];
      end else begin
        din_r <= din_r;
      end
      clk_r  <= active_s && !slot_s[5] && slot_s[0];
      load_r <= !(active_s && (slot_s != SLOT_GAP));
      busy_r <= (state_s != ST_IDLE);
    end
  end

  assign max_din  = din_r;
  assign max_clk  = clk_r;
  assign max_load = load_r;
  assign busy     = busy_r;

endmodule

// File: tb/tb_max7219_display.sv
// Self-checking bench: decodes serial frames off the pins and compares them with
// words computed from the display rules with plain decimal arithmetic.
module tb_max7219_display;

  localparam int CLK_DIV = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] data_in = 32'd0;
  logic        max_din, max_clk, max_load, busy;

  int checks = 0;
  int failures = 0;

  logic [15:0] got_q[$];
  logic [15:0] exp_q[$];

  max7219_display #(.CLK_DIV(CLK_DIV), .INTENSITY(4'h8), .PWRUP_CYCLES(16)) dut (
    .clock    (clock),
    .reset    (reset),
    .data_in  (data_in),
    .max_din  (max_din),
    .max_clk  (max_clk),
    .max_load (max_load),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // pin monitor: rebuilds 16-bit words and checks serial timing
  logic        prev_load = 1'b1, prev_clk = 1'b0, prev_din = 1'b0;
  logic        in_frame = 1'b0, have_start = 1'b0;
  logic [15:0] shreg;
  int          run = 0, rises = 0, lowcnt = 0, cyc = 0, last_start = 0;

  always @(posedge clock) begin
    #2;
    cyc++;
    if (reset) begin
      in_frame   = 1'b0;
      have_start = 1'b0;
    end else begin
      if (in_frame && max_load) begin
        check_eq("rises_per_frame", rises, 16);
        check_eq("load_low_len", lowcnt, 33 * CLK_DIV);
        check_eq("tail_low_len", run, CLK_DIV);
        got_q.push_back(shreg);
        in_frame = 1'b0;
      end else if (in_frame) begin
        lowcnt++;
        if (max_clk != prev_clk) begin
          check_eq("clk_phase_len", run, CLK_DIV);
          run = 1;
          if (max_clk) begin
            check_eq("din_stable", max_din, prev_din);
            shreg = {shreg[14:0], max_din};
            rises++;
          end
        end else begin
          run++;
        end
      end
      if (prev_load && !max_load) begin
        if (have_start && (cyc - last_start) < 150) check_eq("frame_len", cyc - last_start, 34 * CLK_DIV);
        have_start = 1'b1;
        last_start = cyc;
        in_frame   = 1'b1;
        lowcnt     = 1;
        run        = 1;
        rises      = 0;
        shreg      = 16'h0000;
      end
    end
    prev_load = max_load;
    prev_clk  = max_clk;
    prev_din  = max_din;
  end

  task automatic step();
    @(posedge clock);
    #3;
  endtask

  task automatic push_init();
    exp_q.push_back(16'h0F00);
    exp_q.push_back(16'h0C00);
    exp_q.push_back(16'h0B07);
    exp_q.push_back(16'h09FF);
    exp_q.push_back(16'h0A08);
    exp_q.push_back(16'h0C01);
  endtask

  // reference: decimal digits of value mod 10^8, digit 1 first
  task automatic push_digits(input logic [31:0] value);
    int d[8];
    int v;
    int msd;
    logic [7:0] b;
    v = int'(value % 32'd100000000);
    msd = 0;
    for (int i = 0; i < 8; i++) begin
      d[i] = v % 10;
      v = v / 10;
      if (d[i] != 0) msd = i;
    end
    for (int i = 0; i < 8; i++) begin
      b = 8'(d[i]);
`ifdef MAX7219_BLANK_EN
      if (i > msd) b = 8'h0F;
`endif
      exp_q.push_back({4'h0, 4'(i + 1), b});
    end
  endtask

  task automatic wait_frames(input int n, input int budget);
    int c = 0;
    while (got_q.size() < n && c < budget) begin
      step();
      c++;
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int c = 0;
    while (busy && c < budget) begin
      step();
      c++;
    end
    check_eq(tag, busy, 1'b0);
  endtask

  task automatic compare_frames(input string tag);
    int n;
    check_eq({tag, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check_eq($sformatf("%s[%0d]", tag, i), got_q[i], exp_q[i]);
  endtask

  task automatic refresh(input string tag, input logic [31:0] value);
    got_q.delete();
    exp_q.delete();
    push_digits(value);
    data_in = value;
    wait_frames(8, 3000);
    wait_idle({tag, "_idle"}, 200);
    compare_frames(tag);
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] last_v;
    int n;

    repeat (3) step();
    check_eq("rst_load", max_load, 1'b1);
    check_eq("rst_clk", max_clk, 1'b0);
    check_eq("rst_din", max_din, 1'b0);
    check_eq("rst_busy", busy, 1'b1);

    // power-up wait, init sequence and forced refresh of 0
    push_init();
    push_digits(32'd0);
    reset = 1'b0;
    n = 0;
    while (max_load && n < 100) begin
      step();
      n++;
    end
    check_eq("pwrup_cycles", n, 16);
    wait_frames(14, 5000);
    wait_idle("init_idle", 200);
    compare_frames("init");

    refresh("d1234", 32'd1234);
    refresh("d123456789", 32'd123456789);
    last_v = 32'd123456789;
    for (int k = 0; k < 8; k++) begin
      v = ($urandom_range(0, 1) == 0) ? $urandom : $urandom_range(0, 9999);
      if (v == last_v) v = v + 32'd1;
      refresh($sformatf("rnd%0d", k), v);
      last_v = v;
    end
    refresh("d100000000", 32'd100000000);

    // changes during SEND: the 5 set completes, then exactly one refresh of 7
    got_q.delete();
    exp_q.delete();
    push_digits(32'd5);
    push_digits(32'd7);
    data_in = 32'd5;
    wait_frames(2, 3000);
    data_in = 32'd6;
    wait_frames(3, 3000);
    data_in = 32'd7;
    wait_frames(16, 6000);
    wait_idle("queue_idle", 400);
    repeat (400) step();
    compare_frames("queue");

    // reset in the middle of the third digit frame
    got_q.delete();
    data_in = 32'd42;
    wait_frames(2, 3000);
    n = 0;
    while (max_load && n < 100) begin
      step();
      n++;
    end
    repeat (20) step();
    reset = 1'b1;
    step();
    check_eq("midrst_load", max_load, 1'b1);
    check_eq("midrst_clk", max_clk, 1'b0);
    check_eq("midrst_busy", busy, 1'b1);
    reset = 1'b0;
    got_q.delete();
    exp_q.delete();
    push_init();
    push_digits(32'd42);
    wait_frames(14, 5000);
    wait_idle("restart_idle", 200);
    compare_frames("restart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
